// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, frame size and keyboard command codes
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        RELEASE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK_CODE    = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizer with falling-edge detect for one PS/2 line
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic sync,
    output logic fall
);

    logic meta;
    logic prev;

    // Flops reset high so an idle (pulled-up) line never produces a spurious fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with ACK check and watchdog
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       tx_err,
    input  logic       ps2clk,
    input  logic       data,
    output logic       ps2clk_low,
    output logic       data_low
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] bitcnt, bitcnt_n;
    logic [FRAME_BITS-2:0] shreg, shreg_n;
    logic drv, drv_n;
    logic ack_fail, ack_fail_n;
    logic busy_n, done_n, tx_err_n;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .line  (ps2clk),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .line  (data),
        .sync  (data_sync),
        .fall  (data_fall_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            drv      <= 1'b0;
            ack_fail <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            drv      <= drv_n;
            ack_fail <= ack_fail_n;
            busy     <= busy_n;
            done     <= done_n;
            tx_err   <= tx_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        drv_n      = drv;
        ack_fail_n = ack_fail;
        busy_n     = busy;
        done_n     = 1'b0;
        tx_err_n   = tx_err;

        case (state)
            IDLE: begin
                // done is still high on the first IDLE cycle, which blocks back-to-back accepts
                if (tx_start && !done) begin
                    shreg_n    = {1'b1, ~^tx_data, tx_data};
                    busy_n     = 1'b1;
                    tx_err_n   = 1'b0;
                    ack_fail_n = 1'b0;
                    cnt_n      = '0;
                    bitcnt_n   = '0;
                    state_n    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    state_n = REQ;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REQ, SEND: begin
                if (clk_fall) begin
                    drv_n    = shreg[0];
                    shreg_n  = shreg >> 1;
                    bitcnt_n = (state == REQ) ? 4'd1 : bitcnt + 1'b1;
                    cnt_n    = '0;
                    if (state == REQ) begin
                        state_n = SEND;
                    end else if (bitcnt == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_fail_n = data_sync;
                    cnt_n      = '0;
                    state_n    = RELEASE;
                end
            end
            RELEASE: begin
                if (clk_sync && data_sync) begin
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    tx_err_n = ack_fail;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Watchdog runs only while waiting on the device and nothing else moved the FSM.
        if ((state inside {REQ, SEND, ACK, RELEASE}) && !clk_fall && (state_n == state)) begin
            if (cnt == TO_LAST) begin
                state_n  = IDLE;
                done_n   = 1'b1;
                busy_n   = 1'b0;
                tx_err_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign ps2clk_low = (state == INHIBIT);

    always_comb begin
        data_low = 1'b0;
        case (state)
            INHIBIT: data_low = (cnt == INH_LAST);
            REQ:     data_low = 1'b1;
            SEND:    data_low = ~drv;
            default: data_low = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 keyboard device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, tx_err, ps2clk_low, data_low;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    wire  ps2clk_line = dev_clk & ~ps2clk_low;
    wire  data_line   = dev_data & ~data_low;

    int errors = 0;
    int checks = 0;

    // device model state: 0 = ACK, 1 = no ACK, 2 = never clocks
    int         dev_mode = 0;
    int         dev_edges = 0;
    logic [9:0] dev_frame = '0;
    logic       dev_abort = 1'b0;
    logic       rel_flag = 1'b0;
    logic       saw_low = 1'b0;

    // reference model state for the per-cycle compare
    logic m_busy = 1'b0;
    logic m_err = 1'b0;
    logic m_done_prev = 1'b0;
    logic exp_done;
    int   m_k = 0;
    int   m_cd = 0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .tx_err     (tx_err),
        .ps2clk     (ps2clk_line),
        .data       (data_line),
        .ps2clk_low (ps2clk_low),
        .data_low   (data_low)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b};
    endfunction

    task automatic dev_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset) dev_abort = 1'b1;
            if (dev_abort) return;
        end
    endtask

    task automatic dev_frame_run();
        dev_abort = 1'b0;
        dev_edges = 0;
        dev_frame = '0;
        dev_wait(10);
        for (int i = 1; i <= 11; i++) begin
            if (dev_abort) break;
            if (i == 11 && dev_mode == 0) dev_data = 1'b0;
            dev_clk = 1'b0;
            dev_edges = i;
            dev_wait(20);
            if (dev_abort) break;
            dev_clk = 1'b1;
            if (i <= 10) dev_frame[i-1] = data_line;
            else if (dev_data) rel_flag = 1'b1;
            dev_wait(i == 11 ? 5 : 20);
        end
        if (!dev_abort && !dev_data) begin
            dev_data = 1'b1;
            rel_flag = 1'b1;
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    // Keyboard: answers a request-to-send (clock released after inhibit, data low).
    initial begin
        forever begin
            @(negedge clk);
            if (ps2clk_low) begin
                saw_low = 1'b1;
            end else begin
                if (saw_low && !data_line && dev_mode != 2 && !reset) dev_frame_run();
                saw_low = 1'b0;
            end
        end
    end

    // Cycle-level model: timing measured in cycles since the accepting clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_busy = 1'b0; m_err = 1'b0; m_done_prev = 1'b0;
                m_k = 0; m_cd = 0; rel_flag = 1'b0;
                continue;
            end
            exp_done = 1'b0;
            if (m_busy) begin
                m_k++;
                if (rel_flag) begin
                    rel_flag = 1'b0;
                    m_cd = 3;
                end
                if (m_cd > 0) begin
                    m_cd--;
                    if (m_cd == 0) exp_done = 1'b1;
                end
                if (dev_mode == 2 && m_k == INH + TO + 1) exp_done = 1'b1;
                if (exp_done) begin
                    m_busy = 1'b0;
                    m_err  = (dev_mode != 0);
                end
            end else if (tx_start && !m_done_prev) begin
                m_busy = 1'b1; m_k = 1; m_err = 1'b0; m_cd = 0;
            end
            check("busy", busy, m_busy);
            check("done", done, exp_done);
            check("tx_err", tx_err, m_err);
            check("ps2clk_low", ps2clk_low, m_busy && m_k <= INH);
            if (!m_busy || m_k <= INH + 8)
                check("data_low", data_low, m_busy && m_k >= INH);
            m_done_prev = done;
        end
    end

    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done missing after %0d cycles", max);
        end
    endtask

    task automatic wait_edges(input int e);
        int n = 0;
        while (dev_edges < e && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("device_edges", dev_edges, e);
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_ps2clk_low", ps2clk_low, 0);
        check("rst_data_low", data_low, 0);
        reset = 1'b0;
        @(negedge clk);

        // 0xED with device ACK, plus an ignored start while busy
        dev_mode = 0; dev_edges = 0;
        start(CMD_SET_LED);
        wait_edges(3);
        start(8'h00);
        wait_done(3000, n);
        check("ed_frame_lit", dev_frame, 10'h3ED);
        check("ed_frame_model", dev_frame, frame_of(CMD_SET_LED));
        check("ed_tx_err", tx_err, 0);

        // start on the done cycle is dropped, accepted one cycle later; 0xF4 without ACK
        dev_mode = 1; dev_edges = 0;
        tx_data = CMD_ENABLE; tx_start = 1'b1;
        @(negedge clk);
        check("start_on_done_ignored", busy, 0);
        @(negedge clk);
        tx_start = 1'b0;
        check("start_after_done_accepted", busy, 1);
        wait_done(3000, n);
        check("f4_frame_lit", dev_frame, 10'h2F4);
        check("f4_frame_model", dev_frame, frame_of(CMD_ENABLE));
        check("f4_tx_err", tx_err, 1);
        @(negedge clk);

        // silent device: watchdog expires 200 cycles after the inhibit
        dev_mode = 2;
        start(CMD_SET_LED);
        wait_done(3000, n);
        check("timeout_latency", n, INH + TO);
        check("timeout_tx_err", tx_err, 1);
        check("timeout_lines", {ps2clk_low, data_low}, 2'b00);
        @(negedge clk);

        // reset during bit 4 of a 0xFF transfer
        dev_mode = 0; dev_edges = 0;
        start(CMD_RESET);
        wait_edges(5);
        repeat (5) @(negedge clk);
        check("busy_before_reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_lines", {ps2clk_low, data_low}, 2'b00);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        dev_edges = 0;
        start(CMD_RESET);
        wait_done(3000, n);
        check("ff_frame_lit", dev_frame, 10'h3FF);
        check("ff_frame_model", dev_frame, frame_of(CMD_RESET));
        check("ff_tx_err", tx_err, 0);
        repeat (3) @(negedge clk);
        check("final_idle", {busy, ps2clk_low, data_low}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGA to the keyboard over the same ps2clk/data lines used by the receive shifter. It runs on the system clock, samples the device-generated ps2clk, and drives both lines only open-drain (pull low or release). It signals completion, device ACK failure, and timeout to the keyboard controller.

Parameters:
INHIBIT_CYCLES, 5000, system-clock cycles ps2clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max system-clock cycles between consecutive device falling edges, or until both lines go idle (15 ms)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_data  in  8  command byte; latched on accepted tx_start
tx_start  in  1  single-cycle request; ignored while busy=1
busy  out  1  high from accepted tx_start until done
done  out  1  one-cycle pulse at end of transaction, success or failure
tx_err  out  1  valid with done: 1 = no ACK or timeout
ps2clk  in  1  raw PS/2 clock line (asynchronous)
data  in  1  raw PS/2 data line (asynchronous)
ps2clk_low  out  1  1 = pull PS/2 clock low, 0 = release
data_low  out  1  1 = pull PS/2 data low, 0 = release

Behaviour:
- Reset: async; busy=0, done=0, tx_err=0, ps2clk_low=0, data_low=0, state=IDLE, counters=0. Reset mid-transfer releases both lines immediately.
- Input conditioning: ps2clk and data each pass through 2-FF synchronizers. fall = prev_sync & ~cur_sync (one system clock after the sync stage). Only synchronized values are used.
- Frame: shift register {stop=1, parity=~^tx_data, tx_data[7:0]} latched at accept; data sent LSB first; parity is odd.
- IDLE: outputs released. tx_start=1 -> latch frame, busy=1 next cycle, go to INHIBIT.
- INHIBIT: ps2clk_low=1 for INHIBIT_CYCLES cycles. data_low=1 in the final cycle (start bit). Then go to REQ.
- REQ: ps2clk_low=0, data_low=1. Watchdog is cleared. First fall -> drive bit0, bitcnt=1, go to SEND.
- SEND: on each fall, drive the next frame bit (data_low = ~bit), bitcnt++. Edges 1..8 drive data bits, edge 9 drives parity, edge 10 drives stop (data_low=0). After edge 10, go to ACK.
- ACK: on fall 11, sample synchronized data. 0 -> ack_ok; 1 -> ack_fail. Go to RELEASE.
- RELEASE: wait until synchronized ps2clk=1 and data=1 together. Then done=1 for one cycle, tx_err=ack_fail, busy=0, go to IDLE.
- Watchdog: active in REQ/SEND/ACK/RELEASE. Cleared on each fall and on state entry. When it reaches TIMEOUT_CYCLES:
  - release both lines;
  - done=1 and tx_err=1 in the same cycle;
  - go to IDLE.
- tx_err is held until the next accepted tx_start. done is a pulse only.
- A fall observed in INHIBIT or IDLE is ignored. The receive path is not blocked by this block; the controller gates it using busy.
- A tx_start arriving in the same cycle as done is ignored. It is accepted from IDLE on the following cycle.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SEND, ACK, RELEASE);
  - FRAME_BITS=11;
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, ACK_CODE=8'hFA.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one line, instantiated for ps2clk and data. Reusable by the receive shifter.

Test Plan:
All scenarios use INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=200. The bench device model generates a 40-cycle-period ps2clk after seeing the clock released with data low.
- Send 0xED, device ACKs low on edge 11 -> ps2clk_low high for exactly 20 cycles; bits on data_low-inverted line are 1,0,1,1,0,1,1,1; parity=1; stop=1; done pulse with tx_err=0; busy returns to 0.
- Send 0xF4, device leaves data high at edge 11 -> parity bit 0; done with tx_err=1.
- Device never clocks after REQ -> both lines released 200 cycles after INHIBIT ends; done=1, tx_err=1.
- tx_start=1 with 0x00 while busy during a 0xED transfer -> ignored; transmitted bits are still those of 0xED.
- Assert reset at bit 4 of a 0xFF transfer -> ps2clk_low=0, data_low=0, busy=0 asynchronously. A new 0xFF after reset completes with parity 1 (8 ones) and tx_err=0.
